// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and bus widths.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-lane writes and a registered read port.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_we,
  input  logic              i_ok,
  input  logic [AW-1:0]     i_idx,
  input  logic [BE_W-1:0]   i_be,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Storage deliberately has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (i_en && i_we && i_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register doubles as the response data: zero for stores and rejected requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= {WORD_W{1'b0}};
    end else if (i_en) begin
      r_rdata <= (i_we || !i_ok) ? {WORD_W{1'b0}} : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: request/response handshake, programmable wait states.
// Optional address checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              w_access;
  logic              w_ok;
  logic [WORD_W-1:0] w_arr_rdata;

`ifdef DMEM_ERR_CHECK_EN
  assign w_ok = (r_addr[1:0] == 2'b00) && (r_addr < ADDR_LIMIT);
`else
  assign w_ok = 1'b1;
`endif

  // The first RESP cycle performs the array access; rsp_valid rises on that edge.
  assign w_access = (r_state == ST_RESP) && !r_rsp_valid;

  // Handshake FSM with request capture and registered response flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= {WORD_W{1'b0}};
      r_be        <= {BE_W{1'b0}};
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            if (WAIT_STATES > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= 4'(WAIT_STATES);
            end else begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_ok;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= 4'd0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_access),
    .i_we   (r_write),
    .i_ok   (w_ok),
    .i_idx  (r_addr[AW+1:2]),
    .i_be   (r_be),
    .i_wdata(r_wdata),
    .o_rdata(w_arr_rdata)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = w_arr_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
